// File: rtl/msx_cart_pkg.sv
// Shared definitions for the MSX cartridge responder: FSM state codes,
// address-window constants, strobe bit positions and address helpers.
package msx_cart_pkg;

    localparam int MEM_AW = 21;

    // Mapped read window and the ASCII8 bank-register write window
    localparam logic [15:0] WIN_LO = 16'h4000;
    localparam logic [15:0] WIN_HI = 16'hC000;
    localparam logic [15:0] REG_LO = 16'h6000;
    localparam logic [15:0] REG_HI = 16'h8000;

    // Value presented on the data bus when nothing valid is available
    localparam logic [7:0] IDLE_DATA = 8'hFF;

    // FSM state codes
    typedef logic [2:0] cart_state_t;
    localparam cart_state_t ST_IDLE = 3'd0;
    localparam cart_state_t ST_REQ  = 3'd1;
    localparam cart_state_t ST_HOLD = 3'd2;
    localparam cart_state_t ST_WREG = 3'd3;
    localparam cart_state_t ST_IORD = 3'd4;

    // Bit positions inside the synchronized strobe vector
    localparam int STB_SLTSL = 0;
    localparam int STB_RD    = 1;
    localparam int STB_WR    = 2;
    localparam int STB_MREQ  = 3;
    localparam int STB_IORQ  = 4;

    // Pages 2..5 (ADDR[15:13]) map to banks 0..3; inside the read window
    // that is simply ADDR[14:13] with the upper bit inverted.
    function automatic logic [1:0] win_bank(input logic [1:0] a14_13);
        return a14_13 ^ 2'b10;
    endfunction

    // 8-bit bank number above a 13-bit page offset fills 21 bits exactly
    function automatic logic [MEM_AW-1:0] mem_byte_addr(input logic [7:0]  bank,
                                                        input logic [12:0] ofs);
        return {bank, ofs};
    endfunction

endpackage

// File: rtl/msx_cart_responder_if.sv
// MSX slot bus plus external memory port as seen by the cartridge responder.
// slave  : the cartridge (responder) side
// master : the host / memory side that drives strobes and acknowledges
interface msx_cart_responder_if;
    import msx_cart_pkg::*;

    logic [15:0]       ADDR;
    logic [7:0]        DATA_I;
    logic [7:0]        DATA_O;
    logic              DATA_OE;
    logic              SLTSL_n;
    logic              RD_n;
    logic              WR_n;
    logic              MREQ_n;
    logic              IORQ_n;
    logic              WAIT_n;
    logic              BUSDIR_n;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport slave (
        input  ADDR, DATA_I, SLTSL_n, RD_n, WR_n, MREQ_n, IORQ_n,
               mem_rdata, mem_ack,
        output DATA_O, DATA_OE, WAIT_n, BUSDIR_n, mem_addr, mem_rd
    );

    modport master (
        output ADDR, DATA_I, SLTSL_n, RD_n, WR_n, MREQ_n, IORQ_n,
               mem_rdata, mem_ack,
        input  DATA_O, DATA_OE, WAIT_n, BUSDIR_n, mem_addr, mem_rd
    );

endinterface

// File: rtl/msx_bus_sync.sv
// Multi-flop synchronizer for the asynchronous active-low MSX strobes,
// with a high-to-low edge detect on each synchronized strobe.
module msx_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] async_n,
    output logic [WIDTH-1:0] sync_n,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift strobes through the synchronizer; reset to the idle (high) level
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '1;
            prev_q <= '1;
        end else begin
            stage_q[0] <= async_n;
            for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_n = stage_q[SYNC_STAGES-1];
    assign fall   = prev_q & ~sync_n;

endmodule

// File: rtl/msx_cart_responder.sv
// MSX cartridge-side slot responder with an ASCII8-style mapper.
// Reads in 0x4000-0xBFFF are forwarded to a 21-bit memory port with WAIT_n
// stretching the Z80 cycle; writes to 0x6000-0x7FFF load the bank registers.
// Optional build macro MSXCART_IOPORT_EN adds an I/O control register whose
// bit 0 write-protects the bank registers.
module msx_cart_responder
    import msx_cart_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 255,
    parameter logic [7:0] IO_PORT     = 8'h7F
) (
    input  logic                CLK,
    input  logic                RESET,
    msx_cart_responder_if.slave bus
);

`ifdef MSXCART_IOPORT_EN
    localparam int NSTB = 5;
`else
    localparam int NSTB = 4;
`endif
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [NSTB-1:0] stb_async_n, stb_s, stb_fall;
    logic            sltsl_s, rd_s, wr_s, mreq_s;
    logic            mem_access, rd_edge, wr_edge, in_rd_win, in_reg_win;
    logic            bank_wr_en;

    cart_state_t       state_q;
    logic [7:0]        bank_q [4];
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        data_o_q;
    logic              data_oe_q, wait_n_q, busdir_n_q, mem_rd_q;
    logic [MEM_AW-1:0] mem_addr_q;

`ifdef MSXCART_IOPORT_EN
    logic [7:0] ctrl_q;
    logic       io_hit;
    logic       unused_fall;

    assign stb_async_n = {bus.IORQ_n, bus.MREQ_n, bus.WR_n, bus.RD_n, bus.SLTSL_n};
    // An I/O cycle aimed at our control port, never a memory cycle
    assign io_hit      = !stb_s[STB_IORQ] && stb_s[STB_MREQ] && (bus.ADDR[7:0] == IO_PORT);
    assign bank_wr_en  = !ctrl_q[0];
    assign unused_fall = ^{stb_fall[STB_SLTSL], stb_fall[STB_MREQ], stb_fall[STB_IORQ]};
`else
    logic unused_fall;
    logic unused_io;

    assign stb_async_n = {bus.MREQ_n, bus.WR_n, bus.RD_n, bus.SLTSL_n};
    assign bank_wr_en  = 1'b1;
    assign unused_fall = ^{stb_fall[STB_SLTSL], stb_fall[STB_MREQ]};
    assign unused_io   = ^{IO_PORT, bus.IORQ_n};
`endif

    msx_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NSTB)
    ) u_sync (
        .CLK     (CLK),
        .RESET   (RESET),
        .async_n (stb_async_n),
        .sync_n  (stb_s),
        .fall    (stb_fall)
    );

    assign sltsl_s    = stb_s[STB_SLTSL];
    assign rd_s       = stb_s[STB_RD];
    assign wr_s       = stb_s[STB_WR];
    assign mreq_s     = stb_s[STB_MREQ];
    assign mem_access = !sltsl_s && !mreq_s;

    // RD and WR low together is illegal: an edge only counts if the other strobe is high
    assign rd_edge    = stb_fall[STB_RD] && wr_s;
    assign wr_edge    = stb_fall[STB_WR] && rd_s;

    assign in_rd_win  = (bus.ADDR >= WIN_LO) && (bus.ADDR < WIN_HI);
    assign in_reg_win = (bus.ADDR >= REG_LO) && (bus.ADDR < REG_HI);

    // Responder FSM, bank registers and all registered bus/memory outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
            cnt_q      <= '0;
            data_o_q   <= IDLE_DATA;
            data_oe_q  <= 1'b0;
            wait_n_q   <= 1'b1;
            busdir_n_q <= 1'b1;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
`ifdef MSXCART_IOPORT_EN
            ctrl_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_edge && mem_access && in_rd_win) begin
                        state_q    <= ST_REQ;
                        wait_n_q   <= 1'b0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= mem_byte_addr(bank_q[win_bank(bus.ADDR[14:13])],
                                                    bus.ADDR[12:0]);
                        cnt_q      <= '0;
                    end else if (wr_edge && mem_access && in_reg_win) begin
                        state_q <= ST_WREG;
                        if (bank_wr_en) bank_q[bus.ADDR[12:11]] <= bus.DATA_I;
                    end
`ifdef MSXCART_IOPORT_EN
                    else if (rd_edge && io_hit) begin
                        state_q    <= ST_IORD;
                        data_o_q   <= ctrl_q;
                        data_oe_q  <= 1'b1;
                        busdir_n_q <= 1'b0;
                    end else if (wr_edge && io_hit) begin
                        state_q <= ST_WREG;
                        ctrl_q  <= bus.DATA_I;
                    end
`endif
                end
                ST_REQ: begin
                    if (bus.mem_ack || (cnt_q == TO_LAST)) begin
                        state_q    <= ST_HOLD;
                        data_o_q   <= bus.mem_ack ? bus.mem_rdata : IDLE_DATA;
                        mem_rd_q   <= 1'b0;
                        wait_n_q   <= 1'b1;
                        data_oe_q  <= 1'b1;
                        busdir_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Deselecting the slot ends the drive as well as RD returning high
                    if (rd_s || sltsl_s) begin
                        state_q    <= ST_IDLE;
                        data_oe_q  <= 1'b0;
                        busdir_n_q <= 1'b1;
                    end
                end
                ST_IORD: begin
                    if (rd_s) begin
                        state_q    <= ST_IDLE;
                        data_oe_q  <= 1'b0;
                        busdir_n_q <= 1'b1;
                    end
                end
                ST_WREG: begin
                    if (wr_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.DATA_O   = data_o_q;
    assign bus.DATA_OE  = data_oe_q;
    assign bus.WAIT_n   = wait_n_q;
    assign bus.BUSDIR_n = busdir_n_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

// File: doc/msx_cart_responder.md
Name: msx_cart_responder

Overview:
- Cartridge-side responder on the MSX slot bus: the target end of the bus our master drives.
- Samples the asynchronous MSX strobes (SLTSL_n, RD_n, WR_n, MREQ_n, IORQ_n) in the CLK domain.
- Implements an ASCII8-style mapper with four 8 KB bank registers.
- Reads in 0x4000-0xBFFF go to a 21-bit external memory port under a req/ack handshake, with WAIT_n stretching the Z80 cycle.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on bus strobes (≥2).
- TIMEOUT, 255, CLK cycles to wait for mem_ack before aborting a read.
- IO_PORT, 8'h7F, I/O port address for the optional control register.

Ports:
- CLK  in  1  system clock (≥8× MSX clock).
- RESET  in  1  synchronous reset, active-high, sampled on CLK rising edge.
- ADDR  in  16  MSX address bus.
- DATA_I  in  8  MSX data bus, input side.
- DATA_O  out  8  MSX data bus, output side.
- DATA_OE  out  1  drive enable for DATA_O.
- SLTSL_n, RD_n, WR_n, MREQ_n, IORQ_n  in  1 each  MSX strobes, active-low, asynchronous.
- WAIT_n  out  1  wait request to the Z80, active-low.
- BUSDIR_n  out  1  low while the cartridge drives data.
- mem_addr  out  21  external memory byte address.
- mem_rd  out  1  read request, held until ack.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.

Behaviour:
- Clock and reset: one clock, CLK. Synchronous active-high RESET.
- Reset values:
  - DATA_OE=0, DATA_O=8'hFF, WAIT_n=1, BUSDIR_n=1, mem_rd=0, mem_addr=0.
  - bank[0..3]=0.
  - FSM=IDLE.
  - RESET asserted mid-access aborts immediately: WAIT_n released and drivers off the next edge, pending mem_ack ignored.
- Synchronization: strobes pass through SYNC_STAGES flops. ADDR and DATA_I are captured in the cycle the synchronized strobe is first seen low (they are stable by then).
- Memory access: mem_access = !SLTSL_s & !MREQ_s.
- Edge rules: RD_s and WR_s both low is illegal and is ignored (stay IDLE). An access is taken only on a high-to-low edge of RD_s/WR_s, never on a held-low level.
- FSM states:
  - IDLE:
    - Read edge, mem_access, ADDR in 0x4000-0xBFFF -> REQ.
    - Write edge, mem_access, ADDR in 0x6000-0x7FFF -> WREG.
    - Anything else is ignored.
  - REQ:
    - WAIT_n=0 in the same cycle as entry, so latency from strobe edge to WAIT_n low is SYNC_STAGES+1 cycles.
    - mem_rd=1.
    - mem_addr = {bank[ADDR[15:13]-2], ADDR[12:0]}.
    - Counter cleared, then counts.
  - REQ exits:
    - mem_ack -> latch mem_rdata into DATA_O, mem_rd=0, WAIT_n=1, DATA_OE=1, BUSDIR_n=0 -> HOLD.
    - Counter reaches TIMEOUT -> DATA_O=8'hFF, same outputs otherwise -> HOLD.
  - HOLD:
    - Drive until RD_s returns high.
    - On the first high cycle: DATA_OE=0, BUSDIR_n=1 -> IDLE.
    - SLTSL_s rising also ends HOLD.
  - WREG:
    - Bank index is ADDR[12:11]: 0x6000 -> bank0, 0x6800 -> bank1, 0x7000 -> bank2, 0x7800 -> bank3.
    - bank[idx] <= DATA_I; no memory access.
    - Wait for WR_s high -> IDLE.
- Bank-to-window mapping:
  - bank0 -> 0x4000-0x5FFF
  - bank1 -> 0x6000-0x7FFF
  - bank2 -> 0x8000-0x9FFF
  - bank3 -> 0xA000-0xBFFF
- Wrap: the 8-bit bank number plus 13-bit offset gives exactly 21 bits; no overflow is possible.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro: MSXCART_IOPORT_EN.
- Enabled: 8-bit control register CTRL, reset 0.
  - Written by an IORQ_n write to ADDR[7:0]==IO_PORT.
  - Read back by an IORQ_n read: 1-cycle response, DATA_OE/BUSDIR_n as in HOLD, no WAIT.
  - CTRL[0]=1 write-protects the bank registers (WREG becomes a no-op).
- Disabled: IORQ_n is ignored entirely and bank writes are always accepted.

Decomposition:
- Package msx_cart_pkg:
  - FSM state enum (IDLE, REQ, HOLD, WREG, IORD).
  - Window constants: 16'h4000, 16'hC000, 16'h6000, 16'h8000.
  - Idle data value 8'hFF.
- Sub-module msx_bus_sync: parameterised SYNC_STAGES synchronizer bank, plus a falling-edge detect per strobe.

Test Plan:
- Reset, then read 0x4000 with mem_ack after 5 cycles returning 8'hA5 -> WAIT_n low for 5 cycles, mem_addr=21'h000000, DATA_O=8'hA5 with DATA_OE=1 until RD_n high.
- Write 8'h12 to 0x7000, then read 0x8123 -> mem_addr=21'h024123 (bank2=0x12).
- Read 0xC000 or 0x0000 -> no mem_rd, WAIT_n=1, DATA_OE=0. Also drive RD_n=WR_n=0 together -> no response.
- Withhold mem_ack -> WAIT_n released after exactly TIMEOUT cycles, DATA_O=8'hFF. A late mem_ack leaves state unchanged.
- Assert RESET during REQ -> next edge: WAIT_n=1, mem_rd=0, DATA_OE=0, banks=0.
- With MSXCART_IOPORT_EN: I/O write 8'h01 to 0x7F, then write 8'h33 to 0x6800 -> bank1 unchanged. I/O read of 0x7F returns 8'h01.
